// File: rtl/multi_mode_arbiter.sv
// rtl/multi_mode_arbiter.sv - N-requester fixed/round-robin arbiter with DELAY-stage registered grant
// Optional grant locking is built only when ARB_LOCK_EN is defined.
module multi_mode_arbiter #(
    parameter int N     = 4,
    parameter int DELAY = 2,
    parameter int IDW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           rr_mode,
    input  logic           lock,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    localparam int PW = $clog2(N);

    logic [PW-1:0]  ptr_q, ptr_d;

    logic [N-1:0]   arb_gnt;
    logic [IDW-1:0] arb_id;
    logic           arb_valid;

    logic [N-1:0]   dec_gnt;
    logic [IDW-1:0] dec_id;
    logic           dec_valid;
    logic           hold;

    logic [N-1:0]   pipe_gnt_q [DELAY];
    logic [N-1:0]   pipe_gnt_d [DELAY];
    logic [IDW-1:0] pipe_id_q  [DELAY];
    logic [IDW-1:0] pipe_id_d  [DELAY];

    // Search order is 0..N-1 in fixed mode, ptr..ptr-1 (circular) in round-robin mode.
    always_comb begin
        int idx;
        arb_gnt   = '0;
        arb_id    = '0;
        arb_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = rr_mode ? (int'(ptr_q) + k) % N : k;
            if (!arb_valid && req[idx]) begin
                arb_valid    = 1'b1;
                arb_gnt[idx] = 1'b1;
                arb_id       = IDW'(idx);
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic           owner_vld_q, owner_vld_d;
    logic [IDW-1:0] owner_q, owner_d;

    assign hold = lock && owner_vld_q && req[owner_q];

    always_comb begin
        owner_vld_d = owner_vld_q;
        owner_d     = owner_q;
        if (dec_valid) begin
            owner_vld_d = 1'b1;
            owner_d     = dec_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
        end
    end

    always_comb begin
        dec_gnt   = arb_gnt;
        dec_id    = arb_id;
        dec_valid = arb_valid;
        if (hold) begin
            dec_gnt          = '0;
            dec_gnt[owner_q] = 1'b1;
            dec_id           = owner_q;
            dec_valid        = 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign hold        = 1'b0;
    assign dec_gnt     = arb_gnt;
    assign dec_id      = arb_id;
    assign dec_valid   = arb_valid;
`endif

    // ptr advances at the decision edge so back-to-back rotations stay correct despite output lag.
    always_comb begin
        int nxt;
        ptr_d = ptr_q;
        nxt   = int'(arb_id) + 1;
        if (nxt >= N) nxt = 0;
        if (rr_mode && arb_valid && !hold) ptr_d = PW'(nxt);
    end

    always_comb begin
        pipe_gnt_d[0] = dec_gnt;
        pipe_id_d[0]  = dec_id;
        for (int i = 1; i < DELAY; i++) begin
            pipe_gnt_d[i] = pipe_gnt_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < DELAY; i++) begin
                pipe_gnt_q[i] <= '0;
                pipe_id_q[i]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < DELAY; i++) begin
                pipe_gnt_q[i] <= pipe_gnt_d[i];
                pipe_id_q[i]  <= pipe_id_d[i];
            end
        end
    end

    assign gnt       = pipe_gnt_q[DELAY-1];
    assign gnt_id    = pipe_id_q[DELAY-1];
    assign gnt_valid = |pipe_gnt_q[DELAY-1];

endmodule
